// File: rtl/triple_buffer_reader.sv
// triple_buffer_reader
//   Read-side controller of a three-buffer frame store. Tracks the newest
//   complete frame, claims it for reading, streams its word addresses to the
//   consumer with a valid/ready handshake, and tells the writer which buffer
//   it may fill next so that reader and writer never share a buffer.
//
//   Optional feature: define TRIPLE_BUFFER_READER_DROP_CNT_EN to add the
//   drop_count[7:0] output, a saturating count of unread frames that were
//   overwritten by a newer one.
module triple_buffer_reader #(
    parameter int width = 16,
    parameter int DEPTH = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_done,
    input  logic [1:0]       wr_buf,
    output logic [1:0]       wr_next_buf,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [width-1:0] rd_addr,
    output logic [1:0]       rd_buf,
    output logic             frame_done,
`ifdef TRIPLE_BUFFER_READER_DROP_CNT_EN
    output logic [7:0]       drop_count,
`endif
    output logic             proto_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [width-1:0] LAST_ADDR = width'(DEPTH - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] latest;
    logic       new_flag;
    logic       wr_accept;
    logic       wr_reject;
    logic       claim;
    logic       xfer;
    logic       last_xfer;

    // Decode of this cycle's events: writer hand-over, claim and consumer transfer.
    always_comb begin
        wr_reject = wr_done && ((wr_buf == rd_buf) || (wr_buf == 2'd3));
        wr_accept = wr_done && !wr_reject;
        claim     = (state == IDLE) && new_flag;
        xfer      = (state == STREAM) && rd_ready;
        last_xfer = xfer && (rd_addr == LAST_ADDR);
    end

    // Buffer offered to the writer: the one that is neither latest nor being read.
    // Right after a claim latest equals rd_buf, leaving two free buffers; the
    // writer is then pointed at the one preceding rd_buf in the 0-1-2 rotation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        wr_next_buf = 2'd0;
        if (latest != rd_buf) begin
            wr_next_buf = 2'd3 - latest - rd_buf;
        end else begin
            case (rd_buf)
                2'd0:    wr_next_buf = 2'd2;
                2'd1:    wr_next_buf = 2'd0;
                2'd2:    wr_next_buf = 2'd1;
                default: wr_next_buf = 2'd0;
            endcase
        end
    end

    // State register of the IDLE/STREAM sequencer.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: claim a pending frame, stream until its last word is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (claim)     state_next = STREAM;
            STREAM:  if (last_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rd_valid = (state == STREAM);

    // Frame bookkeeping, read address counter, frame_done pulse and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: a mid-frame reset must abort streaming at once, so every
        // control register takes the asynchronous reset, including rd_addr.
        if (!reset) begin
            latest     <= 2'd0;
            new_flag   <= 1'b0;
            rd_buf     <= 2'd1;
            rd_addr    <= '0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (wr_reject) begin
                proto_err <= 1'b1;
            end
            // A claim reads the pre-edge latest; a simultaneous hand-over
            // becomes the next pending frame, so new_flag stays set.
            if (wr_accept) begin
                latest   <= wr_buf;
                new_flag <= 1'b1;
            end else if (claim) begin
                new_flag <= 1'b0;
            end
            if (claim) begin
                rd_buf  <= latest;
                rd_addr <= '0;
            end else if (xfer) begin
                rd_addr <= last_xfer ? '0 : rd_addr + width'(1);
            end
        end
    end

`ifdef TRIPLE_BUFFER_READER_DROP_CNT_EN
    // Saturating count of unread frames replaced by a newer one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (wr_accept && new_flag && !claim && (drop_count != 8'hff)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
